cnn_out_framer: RTL

//   Downstream stage of the CNN core. Captures each contiguous out_valid/out_data result burst (4..256 words)

---
 rtl/cnn_out_framer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cnn_out_framer.sv
// cnn_out_framer
//   Captures contiguous result bursts from the CNN core into a word FIFO (the
//   CNN side is never stalled) and re-emits each burst as a byte-serial frame:
//   2-byte length header, 4 bytes per word MSB first, XOR checksum byte.
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid, in_data    result word stream from the CNN core
//   out_ready            downstream accepts a byte
//   out_valid, out_byte  registered frame byte
//   out_last             marks the checksum byte
//   busy                 capture, queued frame or transmission in progress
//   overflow             sticky: at least one input word was discarded
module cnn_out_framer #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        busy,
    output logic        overflow
);
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CSUM} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] cap_cnt_q, cap_cnt_d;
    logic        in_prev_q, in_prev_d;   // previous cycle was inside a burst
    logic        discard_q, discard_d;   // current burst rejected as a whole
    logic        trunc_q, trunc_d;       // FIFO filled during current burst
    logic        ovf_q, ovf_d;
    logic [AW:0] lq_len_q [2];
    logic [AW:0] lq_len_d [2];
    logic        lq_wr_q, lq_wr_d, lq_rd_q, lq_rd_d;
    logic [1:0]  lq_cnt_q, lq_cnt_d;
    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [AW:0] word_cnt_q, word_cnt_d, len_q, len_d;
    logic [7:0]  csum_q, csum_d;
    logic        out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [7:0]  out_byte_q, out_byte_d;

    logic        push, pop, enq, deq, accept, fifo_full, discard_now;
    logic [31:0] head_word;
    logic [7:0]  next_hi;
    logic [15:0] hdr_len;
    logic [AW-1:0] rd_idx_next;

    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    sel_byte = w[31:24];
            2'd1:    sel_byte = w[23:16];
            2'd2:    sel_byte = w[15:8];
            default: sel_byte = w[7:0];
        endcase
    endfunction

    assign accept      = out_valid_q && out_ready;
    assign fifo_full   = (wr_ptr_q - rd_ptr_q) == DEPTH_L;
    assign rd_idx_next = rd_ptr_q[AW-1:0] + AW'(1);
    assign head_word   = mem[rd_ptr_q[AW-1:0]];
    assign next_hi     = mem[rd_idx_next][31:24];
    assign hdr_len     = 16'(lq_len_q[lq_rd_q]);

    // Transmit FSM: the state names the byte currently presented on out_byte.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        len_d       = len_q;
        csum_d      = csum_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        out_last_d  = out_last_q;
        pop         = 1'b0;
        deq         = 1'b0;
        if (accept) begin
            csum_d = csum_q ^ out_byte_q;
        end
        case (state_q)
            IDLE: begin
                if (lq_cnt_q != 2'd0) begin
                    state_d     = HDR_HI;
                    len_d       = lq_len_q[lq_rd_q];
                    csum_d      = 8'h00;
                    out_valid_d = 1'b1;
                    out_byte_d  = hdr_len[15:8];
                    out_last_d  = 1'b0;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    state_d    = HDR_LO;
                    out_byte_d = hdr_len[7:0];
                end
            end
            HDR_LO: begin
                if (accept) begin
                    if (len_q == '0) begin
                        state_d    = CSUM;
                        out_byte_d = csum_d;
                        out_last_d = 1'b1;
                    end else begin
                        state_d    = DATA;
                        byte_cnt_d = 2'd0;
                        word_cnt_d = '0;
                        out_byte_d = head_word[31:24];
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    if (byte_cnt_q == 2'd3) begin
                        pop = 1'b1;
                        if (word_cnt_q == len_q - (AW+1)'(1)) begin
                            state_d    = CSUM;
                            out_byte_d = csum_d;
                            out_last_d = 1'b1;
                        end else begin
                            // The popped word's successor is read one slot ahead.
                            word_cnt_d = word_cnt_q + (AW+1)'(1);
                            byte_cnt_d = 2'd0;
                            out_byte_d = next_hi;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        out_byte_d = sel_byte(head_word, byte_cnt_q + 2'd1);
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    deq         = 1'b1;
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_byte_d  = 8'h00;
                    out_last_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture side and length queue.
    always_comb begin
        in_prev_d   = in_valid;
        cap_cnt_d   = cap_cnt_q;
        discard_d   = discard_q;
        trunc_d     = trunc_q;
        ovf_d       = ovf_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q + (pop ? (AW+1)'(1) : '0);
        lq_len_d    = lq_len_q;
        lq_wr_d     = lq_wr_q;
        lq_rd_d     = lq_rd_q ^ deq;
        enq         = 1'b0;
        push        = 1'b0;
        // A burst arriving with both length slots taken is rejected entirely.
        discard_now = (in_valid && !in_prev_q) ? (lq_cnt_q == 2'd2) : discard_q;

        if (in_valid) begin
            discard_d = discard_now;
            if (discard_now) begin
                ovf_d = 1'b1;
            end else if (!trunc_q && (!fifo_full || pop)) begin
                push      = 1'b1;
                wr_ptr_d  = wr_ptr_q + (AW+1)'(1);
                cap_cnt_d = cap_cnt_q + (AW+1)'(1);
            end else begin
                // Once the FIFO fills, the rest of the burst is dropped even if space frees up.
                trunc_d = 1'b1;
                ovf_d   = 1'b1;
            end
        end else if (in_prev_q) begin
            enq       = !discard_q;
            cap_cnt_d = '0;
            discard_d = 1'b0;
            trunc_d   = 1'b0;
        end

        if (enq) begin
            lq_len_d[lq_wr_q] = cap_cnt_q;
            lq_wr_d           = ~lq_wr_q;
        end
        case ({enq, deq})
            2'b10:   lq_cnt_d = lq_cnt_q + 2'd1;
            2'b01:   lq_cnt_d = lq_cnt_q - 2'd1;
            default: lq_cnt_d = lq_cnt_q;
        endcase
    end

    // NOTE: the word store has no reset; pointers define its valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cap_cnt_q   <= '0;
            in_prev_q   <= 1'b0;
            discard_q   <= 1'b0;
            trunc_q     <= 1'b0;
            ovf_q       <= 1'b0;
            lq_len_q[0] <= '0;
            lq_len_q[1] <= '0;
            lq_wr_q     <= 1'b0;
            lq_rd_q     <= 1'b0;
            lq_cnt_q    <= 2'd0;
            state_q     <= IDLE;
            byte_cnt_q  <= 2'd0;
            word_cnt_q  <= '0;
            len_q       <= '0;
            csum_q      <= 8'h00;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
            out_last_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cap_cnt_q   <= cap_cnt_d;
            in_prev_q   <= in_prev_d;
            discard_q   <= discard_d;
            trunc_q     <= trunc_d;
            ovf_q       <= ovf_d;
            lq_len_q    <= lq_len_d;
            lq_wr_q     <= lq_wr_d;
            lq_rd_q     <= lq_rd_d;
            lq_cnt_q    <= lq_cnt_d;
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign out_last  = out_last_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != IDLE) || (lq_cnt_q != 2'd0) || (cap_cnt_q != '0);

endmodule
